fifo_rd_packer: RTL and testbench

//  Read-side consumer for async_fifo (rd_clk domain). Pops bytes with rd_en/has_data and

---
 rtl/fifo_rd_packer.sv | 82 ++++++++
 tb/tb_fifo_rd_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops bytes and packs PACK of them into one wide word.
// A flush emits whatever has accumulated as a partial word with a lane-keep mask.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       has_data,
  output logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_keep,
  output logic                       busy
);

  localparam int CW = $clog2(PACK + 1);

  logic [DATA_WIDTH-1:0]      acc [PACK];
  logic [CW-1:0]              count;
  logic [CW-1:0]              cnt_eff;
  logic                       pend;
  logic                       flush_pend;
  logic                       out_free;
  logic                       xfer;
  logic                       part_xfer;
  logic                       flush_clr;
  logic [PACK-1:0]            keep_nxt;
  logic [DATA_WIDTH*PACK-1:0] data_nxt;

  always_comb begin
    keep_nxt  = '0;
    data_nxt  = '0;
    out_free  = !out_valid || out_ready;
    part_xfer = out_free && flush_pend && !pend && (count != '0) && (count != CW'(PACK));
    xfer      = (out_free && (count == CW'(PACK))) || part_xfer;
    cnt_eff   = xfer ? '0 : count;
    rd_en     = has_data && !rst && !flush_pend &&
                (({1'b0, cnt_eff} + {{CW{1'b0}}, pend}) < (CW+1)'(PACK));
    // a flush raised on the same cycle as a pop must wait for that byte to land
    flush_clr = part_xfer || ((count == '0) && !pend && !rd_en);
    for (int i = 0; i < PACK; i++) begin
      keep_nxt[i] = CW'(i) < count;
      data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = keep_nxt[i] ? acc[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PACK; i++) begin
      if (!rst && pend && (cnt_eff == CW'(i))) acc[i] <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      pend       <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
    end else begin
      pend       <= rd_en;
      flush_pend <= (flush_pend || flush) && !flush_clr;
      if (pend)      count <= cnt_eff + 1'b1;
      else if (xfer) count <= '0;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= data_nxt;
        out_keep  <= keep_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (count != '0) || pend || out_valid || flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model with one-cycle read latency feeding the packer,
// expected words queued by the stimulus and checked by an independent output monitor.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst, has_data, rd_en, flush, out_valid, out_ready, busy;
  logic [7:0]  rd_data;
  logic [31:0] out_data;
  logic [3:0]  out_keep;

  logic [7:0]  mem [128];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [35:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
    .clk(clk), .rst(rst), .has_data(has_data), .rd_en(rd_en), .rd_data(rd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .busy(busy)
  );

  always #5 clk = ~clk;

  assign has_data = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr[6:0]];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    logic [35:0] e;
    if (rd_en) begin
      rd_cnt++;
      checks++;
      if (!has_data) begin
        errors++;
        $display("FAIL rd_en_empty: rd_en=1 with has_data=%0b, required has_data=1", has_data);
      end
    end
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (!out_valid || out_data !== prev_data || out_keep !== prev_keep) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%h keep=%h, required valid=1 data=%h keep=%h",
                   out_valid, out_data, out_keep, prev_data, prev_keep);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: data=%h keep=%h, required none", out_data, out_keep);
        end else begin
          e = exp_q.pop_front();
          if ({out_keep, out_data} !== e) begin
            errors++;
            $display("FAIL word: data=%h keep=%h, required data=%h keep=%h",
                     out_data, out_keep, e[31:0], e[35:32]);
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_keep = out_keep;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[6:0]] = b;
    wr_ptr++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d words outstanding after %0d cycles, required 0",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_data"},  64'(out_data),  64'd0);
    check({name, "_keep"},  64'(out_keep),  64'd0);
    check({name, "_busy"},  64'(busy),      64'd0);
    check({name, "_rd_en"}, 64'(rd_en),     64'd0);
  endtask

  initial begin
    int cyc;
    int snap;
    logic [7:0] b;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // two full words with a ready consumer
    exp_q.push_back({4'hF, 32'h03020100});
    exp_q.push_back({4'hF, 32'h07060504});
    for (int i = 0; i < 8; i++) push(8'(i));
    wait_drain("t1", 40);
    repeat (3) step();
    check("t1_idle_busy", 64'(busy), 64'd0);

    // backpressure: only two words' worth of bytes may be read
    out_ready = 1'b0;
    snap = rd_cnt;
    exp_q.push_back({4'hF, 32'h03020100});
    exp_q.push_back({4'hF, 32'h07060504});
    exp_q.push_back({4'hF, 32'h0B0A0908});
    for (int i = 0; i < 12; i++) push(8'(i));
    repeat (30) step();
    check("t2_rd_pulses", 64'(rd_cnt - snap), 64'd8);
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_data", 64'(out_data), 64'h03020100);
    check("t2_keep", 64'(out_keep), 64'hF);
    out_ready = 1'b1;
    wait_drain("t2", 40);

    // partial word on flush, then packing restarts at lane 0
    push(8'h10); push(8'h11); push(8'h12);
    repeat (8) step();
    check("t3_no_valid", 64'(out_valid), 64'd0);
    check("t3_busy", 64'(busy), 64'd1);
    exp_q.push_back({4'b0111, 32'h00121110});
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_drain("t3_flush", 20);
    exp_q.push_back({4'hF, 32'h16151413});
    for (int i = 0; i < 4; i++) push(8'(8'h13 + i));
    wait_drain("t3_next", 30);

    // flush with nothing accumulated, then flush on the pop cycle of a lone byte
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_empty_busy", 64'(busy), 64'd0);
    check("t4_empty_valid", 64'(out_valid), 64'd0);
    exp_q.push_back({4'b0001, 32'h00000020});
    push(8'h20);
    flush = 1'b1;
    #1;
    check("t4_rd_en", 64'(rd_en), 64'd1);
    step();
    flush = 1'b0;
    wait_drain("t4", 20);

    // reset with two bytes landed and a third in flight
    push(8'h28); push(8'h29); push(8'h2A);
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    check_reset_values("t5_rst");
    rst = 1'b0;
    step();
    exp_q.push_back({4'hF, 32'h33323130});
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    wait_drain("t5", 30);

    // continuous stream throughput
    for (int k = 0; k < 10; k++) begin
      b = 8'(8'h40 + 4 * k);
      exp_q.push_back({4'hF, b + 8'd3, b + 8'd2, b + 8'd1, b});
    end
    for (int i = 0; i < 40; i++) push(8'(8'h40 + i));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 52) begin
      step();
      cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t6_throughput: %0d words outstanding after %0d cycles, required 0",
               exp_q.size(), cyc);
      exp_q.delete();
    end
    repeat (5) step();
    check("t6_idle_busy", 64'(busy), 64'd0);
    check("t6_fifo_empty", 64'(has_data), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
